// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll arbiter.
package dice_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, SETTLE, CHECK} state_t;

  localparam int THROW_W = 3;
  localparam logic [THROW_W-1:0] THROW_MIN = 3'd1;
  localparam logic [THROW_W-1:0] THROW_MAX = 3'd6;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps for x^8+x^6+x^5+x^4+1 with a left-shifting register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic throw_ok(input logic [THROW_W-1:0] t);
    return (t >= THROW_MIN) && (t <= THROW_MAX);
  endfunction

endpackage

// File: rtl/dice_roll_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/dice_roll_arbiter.sv
// Shares one electronic dice between N players; round-robin grant, random spin, validated result.
// Optional per-player saturating score accumulators when SCORE_ACC_EN is defined.
module dice_roll_arbiter
  import dice_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int MIN_SPIN    = 4,
  parameter int SPIN_RAND_W = 3,
  parameter int MAX_RETRY   = 2,
  localparam int ID_W       = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PLAYERS-1:0]   req,
  output logic [N_PLAYERS-1:0]   grant,
  output logic                   busy,
  output logic                   dice_button,
  input  logic [THROW_W-1:0]     dice_throw,
  output logic [THROW_W-1:0]     result,
  output logic [ID_W-1:0]        result_id,
  output logic                   result_valid,
`ifdef SCORE_ACC_EN
  output logic [N_PLAYERS*8-1:0] score,
`endif
  output logic                   err
);

  localparam int CNT_W   = $clog2(MIN_SPIN + (1 << SPIN_RAND_W) + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  state_t              state_q;
  logic [7:0]          lfsr_q;
  logic [CNT_W-1:0]    spin_cnt_q;
  logic [RETRY_W-1:0]  retry_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     gidx_q;
  logic [ID_W-1:0]     rr_ptr_next;

  logic [N_PLAYERS-1:0] pick_gnt;
  logic [ID_W-1:0]      pick_idx;
  logic                 pick_any;

  rr_arbiter #(
    .N    (N_PLAYERS),
    .ID_W (ID_W)
  ) u_rr (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign rr_ptr_next = (int'(gidx_q) == N_PLAYERS - 1) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant        <= '0;
      busy         <= 1'b0;
      dice_button  <= 1'b0;
      result       <= '0;
      result_id    <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      rr_ptr_q     <= '0;
      retry_q      <= '0;
      spin_cnt_q   <= '0;
      gidx_q       <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant       <= pick_gnt;
            gidx_q      <= pick_idx;
            busy        <= 1'b1;
            dice_button <= 1'b1;
            spin_cnt_q  <= CNT_W'(MIN_SPIN) + CNT_W'(lfsr_q[SPIN_RAND_W-1:0]);
            retry_q     <= '0;
            state_q     <= SPIN;
          end
        end
        SPIN: begin
          if (spin_cnt_q == CNT_W'(1)) begin
            dice_button <= 1'b0;
            state_q     <= SETTLE;
          end else begin
            spin_cnt_q <= spin_cnt_q - 1'b1;
          end
        end
        SETTLE: state_q <= CHECK;
        CHECK: begin
          if (throw_ok(dice_throw) || (retry_q == RETRY_W'(MAX_RETRY))) begin
            result       <= throw_ok(dice_throw) ? dice_throw : '0;
            err          <= err | !throw_ok(dice_throw);
            result_id    <= gidx_q;
            result_valid <= 1'b1;
            rr_ptr_q     <= rr_ptr_next;
            grant        <= '0;
            busy         <= 1'b0;
            state_q      <= IDLE;
          end else begin
            // Respin with the minimum count; grant is held across retries.
            retry_q     <= retry_q + 1'b1;
            spin_cnt_q  <= CNT_W'(MIN_SPIN);
            dice_button <= 1'b1;
            state_q     <= SPIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCORE_ACC_EN
  logic [8:0] score_sum;

  always_comb begin
    score_sum = {1'b0, score[int'(gidx_q)*8 +: 8]} + {6'd0, dice_throw};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score <= '0;
    end else if ((state_q == CHECK) && throw_ok(dice_throw)) begin
      score[int'(gidx_q)*8 +: 8] <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Scoreboard bench for dice_roll_arbiter: stimulus pushes expected results, a monitor checks them.
module tb_dice_roll_arbiter;

  localparam int N_PLAYERS = 2;
  localparam int MIN_SPIN  = 4;
  localparam int ID_W      = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_PLAYERS-1:0]   req;
  logic [N_PLAYERS-1:0]   grant;
  logic                   busy;
  logic                   dice_button;
  logic [2:0]             throw_v;
  logic [2:0]             result;
  logic [ID_W-1:0]        result_id;
  logic                   result_valid;
  logic                   err;
`ifdef SCORE_ACC_EN
  logic [N_PLAYERS*8-1:0] score;
  int                     model_score [N_PLAYERS];
`endif

  always #5 clk = ~clk;

  dice_roll_arbiter #(
    .N_PLAYERS   (N_PLAYERS),
    .MIN_SPIN    (MIN_SPIN),
    .SPIN_RAND_W (3),
    .MAX_RETRY   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .grant        (grant),
    .busy         (busy),
    .dice_button  (dice_button),
    .dice_throw   (throw_v),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
`ifdef SCORE_ACC_EN
    .score        (score),
`endif
    .err          (err)
  );

  typedef struct packed {
    logic [2:0] res;
    logic       id;
    logic       er;
    logic [1:0] retries;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req_v);
    end
  endtask

  // Reference LFSR: x^8+x^6+x^5+x^4+1, value used at the last edge kept in lfsr_prev.
  logic [7:0] lfsr_m, lfsr_prev;
  int         cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_m    <= 8'hA5;
      lfsr_prev <= 8'hA5;
      cyc       <= 0;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
      cyc       <= cyc + 1;
    end
  end

  initial begin
    logic busy_prev = 1'b0;
    int   g_cyc = 0, btn_cnt = 0, spin_s = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && !busy_prev) begin
        g_cyc   = cyc;
        btn_cnt = 0;
        spin_s  = MIN_SPIN + int'(lfsr_prev[2:0]);
      end
      if (dice_button) btn_cnt++;
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e.res));
          check("result_id", 32'(result_id), 32'(e.id));
          check("err", 32'(err), 32'(e.er));
          check("latency", cyc - g_cyc, spin_s + 2 + int'(e.retries) * (MIN_SPIN + 2));
          check("button_cycles", btn_cnt, spin_s + int'(e.retries) * MIN_SPIN);
`ifdef SCORE_ACC_EN
          if (e.res != 3'd0) begin
            model_score[e.id] = model_score[e.id] + int'(e.res);
            if (model_score[e.id] > 255) model_score[e.id] = 255;
          end
          check("score", 32'(score[int'(e.id)*8 +: 8]), 32'(model_score[e.id]));
`endif
        end
      end
      busy_prev = busy;
    end
  end

  task automatic wait_rv(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < budget);
    check("result_valid_timeout", 32'(result_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] tbl [4] = '{3'd1, 3'd5, 3'd3, 3'd6};

  initial begin
    logic id;
`ifdef SCORE_ACC_EN
    foreach (model_score[i]) model_score[i] = 0;
`endif
    rst = 1'b0;
    req = '0;
    throw_v = 3'd4;
    #2;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_button", 32'(dice_button), 0);
    check("rst_result", 32'(result), 0);
    check("rst_result_id", 32'(result_id), 0);
    check("rst_result_valid", 32'(result_valid), 0);
    check("rst_err", 32'(err), 0);

    // Reset mid-SPIN: outputs must drop without a clock edge.
    req = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("spin_button_high", 32'(dice_button), 1);
    #2 rst = 1'b0;
    #1;
    check("async_button", 32'(dice_button), 0);
    check("async_grant", 32'(grant), 0);
    check("async_busy", 32'(busy), 0);
    @(negedge clk);
    exp_q.push_back('{res: 3'd4, id: 1'b0, er: 1'b0, retries: 2'd0});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_grant", 32'(grant), 32'b01);
    check("first_spin_cnt", 32'(MIN_SPIN + int'(lfsr_prev[2:0])), 9);
    wait_rv(100);
    req = '0;

    // Player 1 drops its request mid-spin; the roll still completes.
    @(negedge clk);
    req = 2'b10;
    throw_v = 3'd2;
    exp_q.push_back('{res: 3'd2, id: 1'b1, er: 1'b0, retries: 2'd0});
    repeat (3) @(negedge clk);
    check("p1_grant", 32'(grant), 32'b10);
    req = '0;
    wait_rv(100);
    check("p1_done_busy", 32'(busy), 0);
    @(negedge clk);
    check("p1_idle_busy", 32'(busy), 0);
    check("p1_idle_grant", 32'(grant), 0);

    // Both players requesting: grants alternate starting from player 0.
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      id = k[0];
      exp_q.push_back('{res: tbl[k], id: id, er: 1'b0, retries: 2'd0});
      throw_v = tbl[k];
      wait_rv(100);
      req[id] = 1'b0;
      if (k < 3) begin
        @(posedge clk);
        #1;
        check("alt_grant", 32'(grant), id ? 32'b01 : 32'b10);
        req[id] = 1'b1;
      end
    end

    // Invalid throw three times: two respins then an error result.
    @(negedge clk);
    req = 2'b01;
    throw_v = 3'd7;
    exp_q.push_back('{res: 3'd0, id: 1'b0, er: 1'b1, retries: 2'd2});
    wait_rv(200);
    req = '0;
    check("err_set", 32'(err), 1);

    // Error stays sticky through a later good roll.
    @(negedge clk);
    req = 2'b01;
    throw_v = 3'd6;
    exp_q.push_back('{res: 3'd6, id: 1'b0, er: 1'b1, retries: 2'd0});
    wait_rv(100);
    req = '0;
    check("err_sticky", 32'(err), 1);

`ifdef SCORE_ACC_EN
    for (int k = 0; k < 43; k++) begin
      @(negedge clk);
      req = 2'b01;
      throw_v = 3'd6;
      exp_q.push_back('{res: 3'd6, id: 1'b0, er: 1'b1, retries: 2'd0});
      wait_rv(100);
      req = '0;
    end
    check("score_saturated", 32'(score[7:0]), 255);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
